// File: rtl/det_event_logger_if.sv
// Read-side handshake between the event logger and its consumer.
interface det_event_logger_if #(
    parameter int unsigned TS_W = 16
) ();
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_data;

    // Logger side: presents the head record, observes the consumer's ready.
    modport master (output rd_valid, output rd_data, input rd_ready);
    // Consumer side: accepts records.
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/det_event_logger.sv
// Timestamps rising edges of a detector output into a show-ahead FIFO,
// with saturating event/drop counters, sticky overflow and a level irq.
module det_event_logger #(
    parameter int unsigned TS_W    = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned IRQ_LVL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    det_in,
    input  logic                    ovf_clr,
    det_event_logger_if.master      rd,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    irq,
    output logic                    ovf,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [CNT_W-1:0]        evt_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [TS_W-1:0]  ts;
    logic             det_q;
    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             evt;
    logic             pop;
    logic             push;
    logic             drop;

    // Event qualification and FIFO accept/drop decisions for this edge.
    always_comb begin
        full = (level == LVL_W'(DEPTH));
        evt  = det_in & ~det_q & en;
        pop  = rd.rd_valid & rd.rd_ready;
        push = evt & (~full | pop);
        drop = evt & full & ~pop;
    end

    // Show-ahead head record; zero while empty so idle reads are deterministic.
    assign rd.rd_valid = (level != '0);
    assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
    assign irq         = (level >= LVL_W'(IRQ_LVL));

    // Free-running timestamp and the previous-edge copy of det_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts    <= '0;
            det_q <= 1'b0;
        end else begin
            ts    <= ts + TS_W'(1);
            det_q <= det_in;
        end
    end

    // Record storage; on full+pop the write lands in the slot being vacated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= ts;
        end
    end

    // Pointers wrap naturally; occupancy is tracked separately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating accepted-event total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt <= '0;
        end else if (push && (evt_cnt != {CNT_W{1'b1}})) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

    // Sticky overflow and drop counter; a drop on the clear edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= CNT_W'(1);
            end else if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_det_event_logger.sv
// Self-checking bench for det_event_logger: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_det_event_logger;
    localparam int TS_W    = 16;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int IRQ_LVL = 2;
    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             det_in;
    logic             ovf_clr;
    logic [LVL_W-1:0] level;
    logic             irq;
    logic             ovf;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] evt_cnt;

    det_event_logger_if #(.TS_W(TS_W)) rif ();

    det_event_logger #(
        .TS_W(TS_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .IRQ_LVL(IRQ_LVL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .det_in(det_in), .ovf_clr(ovf_clr),
        .rd(rif), .level(level), .irq(irq), .ovf(ovf),
        .drop_cnt(drop_cnt), .evt_cnt(evt_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int              m_ts;
    bit              m_detq;
    logic [TS_W-1:0] m_q[$];
    bit              m_ovf;
    int              m_drop;
    int              m_evt;

    function automatic void model_reset();
        m_ts = 0; m_detq = 1'b0; m_q.delete(); m_ovf = 1'b0; m_drop = 0; m_evt = 0;
    endfunction

    function automatic void model_step(bit e, bit d, bit r, bit c);
        bit ev;
        ev = d && !m_detq && e;
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (ev && m_q.size() < DEPTH) begin
            m_q.push_back(TS_W'(m_ts));
            if (m_evt < CMAX) m_evt++;
            if (c) begin m_ovf = 1'b0; m_drop = 0; end
        end else if (ev) begin
            m_ovf  = 1'b1;
            m_drop = c ? 1 : ((m_drop < CMAX) ? m_drop + 1 : m_drop);
        end else if (c) begin
            m_ovf = 1'b0; m_drop = 0;
        end
        m_detq = d;
        m_ts   = (m_ts + 1) % (1 << TS_W);
    endfunction

    function automatic logic [TS_W-1:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : '0;
    endfunction

    // One clock: drive inputs away from the edge, advance model, sample after edge.
    task automatic cycle(input bit e, input bit d, input bit r, input bit c);
        en = e; det_in = d; rif.rd_ready = r; ovf_clr = c;
        model_step(e, d, r, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; det_in = 1'b0; rif.rd_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1, 1, 0, 0); cycle(1, 0, 0, 0); cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++; if (rif.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", rif.rd_valid); end
        checks++; if (rif.rd_data !== 16'h0) begin failures++; $display("FAIL reset_data: got %0h want 0", rif.rd_data); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %0b want 0", irq); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        checks++; if (evt_cnt !== 8'd0) begin failures++; $display("FAIL reset_evt: got %0d want 0", evt_cnt); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        repeat (5) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        checks++; if (rif.rd_valid !== 1'b1) begin failures++; $display("FAIL single_latency_valid: got %0b want 1", rif.rd_valid); end
        checks++; if (rif.rd_data !== 16'd5) begin failures++; $display("FAIL single_latency_data: got %0d want 5", rif.rd_data); end
        cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level: got %0d want 1", level); end
        checks++; if (rif.rd_data !== 16'd5) begin failures++; $display("FAIL single_data: got %0d want 5", rif.rd_data); end
        checks++; if (evt_cnt !== 8'd1) begin failures++; $display("FAIL single_evt: got %0d want 1", evt_cnt); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL single_irq: got %0b want 0", irq); end
    endtask

    task automatic test_irq();
        logic [TS_W-1:0] want [3];
        logic            irq_want [3];
        want     = '{16'd0, 16'd2, 16'd4};
        irq_want = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0);
            checks++; if (irq !== irq_want[i]) begin failures++; $display("FAIL irq_after_push%0d: got %0b want %0b", i + 1, irq, irq_want[i]); end
            cycle(1, 0, 0, 0);
        end
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL irq_level: got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rif.rd_data !== want[i]) begin failures++; $display("FAIL irq_order%0d: got %0d want %0d", i, rif.rd_data, want[i]); end
            cycle(1, 0, 1, 0);
        end
        checks++; if (rif.rd_valid !== 1'b0 || rif.rd_data !== 16'h0) begin failures++; $display("FAIL irq_drained: valid %0b data %0h want 0/0", rif.rd_valid, rif.rd_data); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear: got %0b want 0", irq); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
        end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL ovf_level: got %0d want 4", level); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b want 1", ovf); end
        checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        checks++; if (evt_cnt !== 8'd4) begin failures++; $display("FAIL ovf_evt: got %0d want 4", evt_cnt); end
        cycle(1, 0, 0, 1);
        checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL ovf_clr: ovf %0b drop %0d want 0/0", ovf, drop_cnt); end
        checks++; if (level !== 3'd4 || rif.rd_data !== 16'd0) begin failures++; $display("FAIL ovf_clr_fifo: level %0d head %0d want 4/0", level, rif.rd_data); end
    endtask

    // Continues from the full FIFO left by test_overflow (next edge ts=13).
    task automatic test_full_pop_push();
        logic [TS_W-1:0] want [4];
        want = '{16'd2, 16'd4, 16'd6, 16'd13};
        cycle(1, 1, 1, 0);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL fpp_level: got %0d want 4", level); end
        checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL fpp_ovf: ovf %0b drop %0d want 0/0", ovf, drop_cnt); end
        checks++; if (evt_cnt !== 8'd5) begin failures++; $display("FAIL fpp_evt: got %0d want 5", evt_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rif.rd_data !== want[i]) begin failures++; $display("FAIL fpp_order%0d: got %0d want %0d", i, rif.rd_data, want[i]); end
            cycle(1, 0, 1, 0);
        end
        checks++; if (rif.rd_valid !== 1'b0) begin failures++; $display("FAIL fpp_empty: got %0b want 0", rif.rd_valid); end
        cycle(1, 0, 1, 0);
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL fpp_pop_empty: level %0d want 0", level); end
    endtask

    task automatic test_enable();
        do_reset();
        cycle(0, 1, 0, 0);
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL en_off: level %0d want 0", level); end
        cycle(1, 1, 0, 0);
        checks++; if (level !== 3'd0 || evt_cnt !== 8'd0) begin failures++; $display("FAIL en_late: level %0d evt %0d want 0/0", level, evt_cnt); end
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        checks++; if (level !== 3'd1 || rif.rd_data !== 16'd3) begin failures++; $display("FAIL en_fresh: level %0d data %0d want 1/3", level, rif.rd_data); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1, 1, 1, 0); cycle(1, 0, 1, 0);
        end
        checks++; if (evt_cnt !== 8'd255) begin failures++; $display("FAIL sat_evt: got %0d want 255", evt_cnt); end
        for (int i = 0; i < 300; i++) begin
            cycle(1, 1, 0, 0); cycle(1, 0, 0, 0);
        end
        checks++; if (drop_cnt !== 8'd255 || ovf !== 1'b1) begin failures++; $display("FAIL sat_drop: drop %0d ovf %0b want 255/1", drop_cnt, ovf); end
        checks++; if (evt_cnt !== 8'd255 || level !== 3'd4) begin failures++; $display("FAIL sat_hold: evt %0d level %0d want 255/4", evt_cnt, level); end
        cycle(1, 1, 0, 1);
        checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin failures++; $display("FAIL drop_beats_clr: ovf %0b drop %0d want 1/1", ovf, drop_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (65534) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        checks++; if (level !== 3'd2 || rif.rd_data !== 16'hFFFF) begin failures++; $display("FAIL wrap_first: level %0d data %0h want 2/ffff", level, rif.rd_data); end
        cycle(1, 0, 1, 0);
        checks++; if (rif.rd_data !== 16'h0001) begin failures++; $display("FAIL wrap_second: data %0h want 0001", rif.rd_data); end
        rst = 1'b1;
        #1;
        checks++; if (level !== 3'd0 || rif.rd_valid !== 1'b0) begin failures++; $display("FAIL midrun_reset: level %0d valid %0b want 0/0", level, rif.rd_valid); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int rp;
        bit e, d, r, c;
        do_reset();
        rp = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) rp = (i / 200 % 3 == 0) ? 10 : ((i / 200 % 3 == 1) ? 90 : 50);
            e = ($urandom_range(0, 7) != 0);
            d = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 99) < rp);
            c = ($urandom_range(0, 31) == 0);
            cycle(e, d, r, c);
            checks++; if (rif.rd_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, rif.rd_valid, m_q.size() > 0); end
            checks++; if (rif.rd_data !== m_head()) begin failures++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, rif.rd_data, m_head()); end
            checks++; if (level !== LVL_W'(m_q.size())) begin failures++; $display("FAIL rnd_level@%0d: got %0d want %0d", i, level, m_q.size()); end
            checks++; if (irq !== (m_q.size() >= IRQ_LVL)) begin failures++; $display("FAIL rnd_irq@%0d: got %0b want %0b", i, irq, m_q.size() >= IRQ_LVL); end
            checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", i, ovf, m_ovf); end
            checks++; if (drop_cnt !== CNT_W'(m_drop)) begin failures++; $display("FAIL rnd_drop@%0d: got %0d want %0d", i, drop_cnt, m_drop); end
            checks++; if (evt_cnt !== CNT_W'(m_evt)) begin failures++; $display("FAIL rnd_evt@%0d: got %0d want %0d", i, evt_cnt, m_evt); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; det_in = 1'b0; rif.rd_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_irq();
        test_overflow();
        test_full_pop_push();
        test_enable();
        test_saturate();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
